// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_pkg
// Purpose  : Shared definitions for the pipeline hazard controller.
//            - Forwarding select codes.
//            - Result-class, operand-use-stage and MDU-start enumerations.
//            - Helpers returning the cycles-until-result (tnew) of a
//              producer sitting in E or M.
// Revision : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    // Forwarding select codes shared by every bypass multiplexer
    localparam logic [2:0] SEL_RF     = 3'b000;
    localparam logic [2:0] SEL_PC8_E  = 3'b001;
    localparam logic [2:0] SEL_ALU_M  = 3'b010;
    localparam logic [2:0] SEL_HILO_M = 3'b011;
    localparam logic [2:0] SEL_PC8_M  = 3'b100;
    localparam logic [2:0] SEL_WTDT   = 3'b101;

    // Class of value a producing instruction writes back
    typedef enum logic [1:0] {
        RES_ALU  = 2'd0,
        RES_HILO = 2'd1,
        RES_PC8  = 2'd2,
        RES_LOAD = 2'd3
    } res_class_e;

    // Pipeline stage in which a consumer first needs an operand
    typedef enum logic [1:0] {
        TUSE_D    = 2'd0,
        TUSE_E    = 2'd1,
        TUSE_M    = 2'd2,
        TUSE_NONE = 2'd3
    } tuse_e;

    // Multiply/divide start request carried with the instruction
    typedef enum logic [1:0] {
        MD_NONE = 2'd0,
        MD_MULT = 2'd1,
        MD_DIV  = 2'd2,
        MD_RSVD = 2'd3
    } md_start_e;

    // Cycles until a producer in E has its result on a bypass path
    function automatic logic [1:0] tnew_in_e(input res_class_e res);
        logic [1:0] t;
        case (res)
            RES_PC8:  t = 2'd0;
            RES_LOAD: t = 2'd2;
            default:  t = 2'd1;
        endcase
        return t;
    endfunction

    // Cycles until a producer in M has its result on a bypass path
    function automatic logic [1:0] tnew_in_m(input res_class_e res);
        return (res == RES_LOAD) ? 2'd1 : 2'd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_if
// Purpose  : Bundle between the datapath (master) and the hazard controller
//            (slave).
//   master -> slave : rs_D, rt_D, tuse_rs_D, tuse_rt_D, wa_D, res_D,
//                     md_start_D, md_use_D (decode-stage fields)
//   slave -> master : sel_RS_D, sel_RT_D, sel_RS_E, sel_RT_E, sel_RT_M,
//                     stall, clr_E, md_busy, stall_cnt
// Revision : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if;
    import hazard_pkg::*;

    // Decode-stage fields
    logic [4:0] rs_D;
    logic [4:0] rt_D;
    tuse_e      tuse_rs_D;
    tuse_e      tuse_rt_D;
    logic [4:0] wa_D;
    res_class_e res_D;
    md_start_e  md_start_D;
    logic       md_use_D;

    // Controller results
    logic [2:0]  sel_RS_D;
    logic [2:0]  sel_RT_D;
    logic [2:0]  sel_RS_E;
    logic [2:0]  sel_RT_E;
    logic        sel_RT_M;
    logic        stall;
    logic        clr_E;
    logic        md_busy;
    logic [31:0] stall_cnt;

    modport master (
        output rs_D, rt_D, tuse_rs_D, tuse_rt_D, wa_D, res_D, md_start_D,
               md_use_D,
        input  sel_RS_D, sel_RT_D, sel_RS_E, sel_RT_E, sel_RT_M, stall,
               clr_E, md_busy, stall_cnt
    );

    modport slave (
        input  rs_D, rt_D, tuse_rs_D, tuse_rt_D, wa_D, res_D, md_start_D,
               md_use_D,
        output sel_RS_D, sel_RT_D, sel_RS_E, sel_RT_E, sel_RT_M, stall,
               clr_E, md_busy, stall_cnt
    );

endinterface
`default_nettype wire

// File: rtl/hazard_ctrl_fwd_sel.sv
`default_nettype none
// ============================================================================
// Module   : fwd_sel
// Purpose  : Forwarding select and producer tnew for one source operand,
//            searching the E, M and W shadow stages nearest-first.
//   i_src            source register number
//   i_wa_e/i_res_e   E-stage destination and class (tie i_wa_e to 0 for
//                    operands that are themselves in E)
//   i_wa_m/i_res_m   M-stage destination and class
//   i_wa_w           W-stage destination
//   o_sel            3-bit bypass select
//   o_tnew           cycles until the nearest matching producer's result
//                    is available (0 when nothing matches)
// Revision : 1.0 - initial release
// ============================================================================
module fwd_sel
    import hazard_pkg::*;
(
    input  wire logic [4:0] i_src,
    input  wire logic [4:0] i_wa_e,
    input  wire logic [1:0] i_res_e,
    input  wire logic [4:0] i_wa_m,
    input  wire logic [1:0] i_res_m,
    input  wire logic [4:0] i_wa_w,
    output logic      [2:0] o_sel,
    output logic      [1:0] o_tnew
);

    logic       w_hit_e;
    logic       w_hit_m;
    logic       w_hit_w;
    res_class_e w_res_e;
    res_class_e w_res_m;

    // A zero destination means "no write", so $0 can never match
    assign w_hit_e = (i_wa_e != 5'd0) && (i_wa_e == i_src);
    assign w_hit_m = (i_wa_m != 5'd0) && (i_wa_m == i_src);
    assign w_hit_w = (i_wa_w != 5'd0) && (i_wa_w == i_src);
    assign w_res_e = res_class_e'(i_res_e);
    assign w_res_m = res_class_e'(i_res_m);

    // Only the nearest producer is considered; an older match further down
    // the pipe holds a stale value.
    always_comb begin
        o_sel  = SEL_RF;
        o_tnew = 2'd0;
        if (w_hit_e) begin
            o_tnew = tnew_in_e(w_res_e);
            // Only a link address is ready while its producer is in E
            if (w_res_e == RES_PC8) begin
                o_sel = SEL_PC8_E;
            end
        end else if (w_hit_m) begin
            o_tnew = tnew_in_m(w_res_m);
            case (w_res_m)
                RES_ALU:  o_sel = SEL_ALU_M;
                RES_HILO: o_sel = SEL_HILO_M;
                RES_PC8:  o_sel = SEL_PC8_M;
                default:  o_sel = SEL_RF;
            endcase
        end else if (w_hit_w) begin
            o_sel = SEL_WTDT;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Hazard controller for the five-stage MIPS core. Keeps a shadow
//            pipeline of destination tags/result classes for E, M and W,
//            produces the bypass selects, load-use / late-result stalls and
//            tracks multiply/divide busy time.
// Params   : MULT_CYCLES - busy cycles for mult/multu
//            DIV_CYCLES  - busy cycles for div/divu
// Ports    : clk   - system clock
//            rst_n - synchronous active-low reset
//            hz    - hazard_ctrl_if.slave (decode fields in, selects,
//                    stall, clr_E, md_busy, stall_cnt out)
// Macro    : HAZARD_STALL_CNT_EN - when defined, stall_cnt counts stall
//            cycles since reset; otherwise stall_cnt is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    hazard_ctrl_if.slave hz
);

    localparam int c_MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES
                                                         : DIV_CYCLES;
    localparam int c_CNT_W  = $clog2(c_MD_MAX + 1);

    // ------------------------------------------------------------------
    // Shadow pipeline
    // ------------------------------------------------------------------
    logic [4:0] r_rs_E;
    logic [4:0] r_rt_E;
    logic [4:0] r_wa_E;
    res_class_e r_res_E;
    md_start_e  r_md_start_E;
    logic [4:0] r_rt_M;
    logic [4:0] r_wa_M;
    res_class_e r_res_M;
    logic [4:0] r_wa_W;

    logic [c_CNT_W-1:0] r_md_cnt;

    logic [1:0] w_tnew_rs_d;
    logic [1:0] w_tnew_rt_d;
    logic [1:0] w_tnew_rs_e;
    logic [1:0] w_tnew_rt_e;
    logic       w_unused_tnew_e;
    logic [1:0] w_tuse_rs;
    logic [1:0] w_tuse_rt;
    logic       w_stall_rs;
    logic       w_stall_rt;
    logic       w_stall_md;
    logic       w_md_busy;
    logic       w_stall;

    // ------------------------------------------------------------------
    // Operand select units
    // ------------------------------------------------------------------
    fwd_sel u_fwd_rs_d (
        .i_src   (hz.rs_D),
        .i_wa_e  (r_wa_E),
        .i_res_e (r_res_E),
        .i_wa_m  (r_wa_M),
        .i_res_m (r_res_M),
        .i_wa_w  (r_wa_W),
        .o_sel   (hz.sel_RS_D),
        .o_tnew  (w_tnew_rs_d)
    );

    fwd_sel u_fwd_rt_d (
        .i_src   (hz.rt_D),
        .i_wa_e  (r_wa_E),
        .i_res_e (r_res_E),
        .i_wa_m  (r_wa_M),
        .i_res_m (r_res_M),
        .i_wa_w  (r_wa_W),
        .o_sel   (hz.sel_RT_D),
        .o_tnew  (w_tnew_rt_d)
    );

    // Operands already in E have no E-stage producer ahead of them, so the
    // E search is disabled by a zero tag; PC8_E can therefore never appear.
    fwd_sel u_fwd_rs_e (
        .i_src   (r_rs_E),
        .i_wa_e  (5'd0),
        .i_res_e (RES_ALU),
        .i_wa_m  (r_wa_M),
        .i_res_m (r_res_M),
        .i_wa_w  (r_wa_W),
        .o_sel   (hz.sel_RS_E),
        .o_tnew  (w_tnew_rs_e)
    );

    fwd_sel u_fwd_rt_e (
        .i_src   (r_rt_E),
        .i_wa_e  (5'd0),
        .i_res_e (RES_ALU),
        .i_wa_m  (r_wa_M),
        .i_res_m (r_res_M),
        .i_wa_w  (r_wa_W),
        .o_sel   (hz.sel_RT_E),
        .o_tnew  (w_tnew_rt_e)
    );

    // E-stage operands are never stalled on, their tnew is informational
    assign w_unused_tnew_e = |{w_tnew_rs_e, w_tnew_rt_e};

    // Store data in M can still pick up the value being written back
    assign hz.sel_RT_M = (r_rt_M != 5'd0) && (r_rt_M == r_wa_W);

    // ------------------------------------------------------------------
    // Stall generation
    // ------------------------------------------------------------------
    assign w_tuse_rs  = hz.tuse_rs_D;
    assign w_tuse_rt  = hz.tuse_rt_D;
    assign w_stall_rs = (hz.tuse_rs_D != TUSE_NONE) && (w_tnew_rs_d > w_tuse_rs);
    assign w_stall_rt = (hz.tuse_rt_D != TUSE_NONE) && (w_tnew_rt_d > w_tuse_rt);

    // An MDU op starting in E has not loaded the counter yet, so it must be
    // treated as busy too.
    assign w_md_busy  = (r_md_cnt != '0);
    assign w_stall_md = hz.md_use_D && (w_md_busy || (r_md_start_E != MD_NONE));
    assign w_stall    = w_stall_rs || w_stall_rt || w_stall_md;

    assign hz.stall   = w_stall;
    assign hz.clr_E   = w_stall;
    assign hz.md_busy = w_md_busy;

    // ------------------------------------------------------------------
    // Shadow register advance
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rs_E       <= 5'd0;
            r_rt_E       <= 5'd0;
            r_wa_E       <= 5'd0;
            r_res_E      <= RES_ALU;
            r_md_start_E <= MD_NONE;
            r_rt_M       <= 5'd0;
            r_wa_M       <= 5'd0;
            r_res_M      <= RES_ALU;
            r_wa_W       <= 5'd0;
        end else begin
            if (w_stall) begin
                // Bubble: no destination, no MDU start
                r_rs_E       <= 5'd0;
                r_rt_E       <= 5'd0;
                r_wa_E       <= 5'd0;
                r_res_E      <= RES_ALU;
                r_md_start_E <= MD_NONE;
            end else begin
                r_rs_E       <= hz.rs_D;
                r_rt_E       <= hz.rt_D;
                r_wa_E       <= hz.wa_D;
                r_res_E      <= hz.res_D;
                r_md_start_E <= hz.md_start_D;
            end
            r_rt_M  <= r_rt_E;
            r_wa_M  <= r_wa_E;
            r_res_M <= r_res_E;
            r_wa_W  <= r_wa_M;
        end
    end

    // ------------------------------------------------------------------
    // MDU busy counter: a new start always reloads, never accumulates
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_md_cnt <= '0;
        end else if (r_md_start_E == MD_MULT) begin
            r_md_cnt <= c_CNT_W'(MULT_CYCLES);
        end else if (r_md_start_E != MD_NONE) begin
            r_md_cnt <= c_CNT_W'(DIV_CYCLES);
        end else if (r_md_cnt != '0) begin
            r_md_cnt <= r_md_cnt - c_CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Stall cycle counter
    // ------------------------------------------------------------------
`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= 32'd0;
        end else if (w_stall) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign hz.stall_cnt = r_stall_cnt;
`else
    assign hz.stall_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Directed self-checking bench for hazard_ctrl (MULT_CYCLES=5,
//            DIV_CYCLES=10). The bench plays the role of the F/D register,
//            holding the decode fields while a stall is reported.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;
    import hazard_pkg::*;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    int   n_st;
    int   n_bz;

    hazard_ctrl_if hz ();

    hazard_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_d(input logic [4:0] rs, input logic [4:0] rt,
                         input tuse_e trs, input tuse_e trt,
                         input logic [4:0] wa, input res_class_e res,
                         input md_start_e mds, input logic mdu);
        hz.rs_D       = rs;
        hz.rt_D       = rt;
        hz.tuse_rs_D  = trs;
        hz.tuse_rt_D  = trt;
        hz.wa_D       = wa;
        hz.res_D      = res;
        hz.md_start_D = mds;
        hz.md_use_D   = mdu;
    endtask

    task automatic idle();
        set_d(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd0, RES_ALU, MD_NONE, 1'b0);
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic flush();
        idle();
        repeat (4) nxt();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        idle();
        repeat (2) nxt();
        rst_n = 1'b1;
        #1;
        // Reset state
        chk("rst_sel_RS_D", 32'(hz.sel_RS_D), 32'd0);
        chk("rst_sel_RT_D", 32'(hz.sel_RT_D), 32'd0);
        chk("rst_sel_RS_E", 32'(hz.sel_RS_E), 32'd0);
        chk("rst_sel_RT_E", 32'(hz.sel_RT_E), 32'd0);
        chk("rst_sel_RT_M", 32'(hz.sel_RT_M), 32'd0);
        chk("rst_stall",    32'(hz.stall),    32'd0);
        chk("rst_clr_E",    32'(hz.clr_E),    32'd0);
        chk("rst_md_busy",  32'(hz.md_busy),  32'd0);
        chk("rst_stall_cnt", hz.stall_cnt,    32'd0);

        // addu $3 ; subu $5,$3,$4
        nxt(); set_d(5'd1, 5'd2, TUSE_E, TUSE_E, 5'd3, RES_ALU, MD_NONE, 1'b0);
        nxt(); set_d(5'd3, 5'd4, TUSE_E, TUSE_E, 5'd5, RES_ALU, MD_NONE, 1'b0);
        #1;
        chk("alu_stall",    32'(hz.stall),    32'd0);
        chk("alu_sel_RS_D", 32'(hz.sel_RS_D), 32'd0);
        nxt(); idle(); #1;
        chk("alu_sel_RS_E", 32'(hz.sel_RS_E), 32'd2);
        chk("alu_sel_RT_E", 32'(hz.sel_RT_E), 32'd0);
        flush();

        // HILO producer two ahead of consumer
        nxt(); set_d(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd7, RES_HILO, MD_NONE, 1'b0);
        nxt(); idle();
        nxt(); set_d(5'd7, 5'd0, TUSE_E, TUSE_NONE, 5'd0, RES_ALU, MD_NONE, 1'b0);
        #1;
        chk("hilo_sel_RS_D", 32'(hz.sel_RS_D), 32'd3);
        chk("hilo_stall",    32'(hz.stall),    32'd0);
        nxt(); idle(); #1;
        chk("hilo_sel_RS_E", 32'(hz.sel_RS_E), 32'd5);
        flush();

        // lw $4 ; beq $4,$0 : two stall cycles then WtDt in D
        nxt(); set_d(5'd29, 5'd0, TUSE_E, TUSE_NONE, 5'd4, RES_LOAD, MD_NONE, 1'b0);
        nxt(); set_d(5'd4, 5'd0, TUSE_D, TUSE_D, 5'd0, RES_ALU, MD_NONE, 1'b0);
        #1;
        chk("ldbr_stall1", 32'(hz.stall), 32'd1);
        chk("ldbr_clrE1",  32'(hz.clr_E), 32'd1);
        nxt(); #1;
        chk("ldbr_stall2", 32'(hz.stall), 32'd1);
        chk("ldbr_clrE2",  32'(hz.clr_E), 32'd1);
        nxt(); #1;
        chk("ldbr_stall3",   32'(hz.stall),    32'd0);
        chk("ldbr_sel_RS_D", 32'(hz.sel_RS_D), 32'd5);
        flush();

        // lw $9 ; addu $x,$9 : one stall then WtDt in E
        nxt(); set_d(5'd29, 5'd0, TUSE_E, TUSE_NONE, 5'd9, RES_LOAD, MD_NONE, 1'b0);
        nxt(); set_d(5'd9, 5'd0, TUSE_E, TUSE_NONE, 5'd10, RES_ALU, MD_NONE, 1'b0);
        #1;
        chk("ldu_stall1", 32'(hz.stall), 32'd1);
        nxt(); #1;
        chk("ldu_stall2",   32'(hz.stall),    32'd0);
        chk("ldu_sel_RS_D", 32'(hz.sel_RS_D), 32'd0);
        nxt(); idle(); #1;
        chk("ldu_sel_RS_E", 32'(hz.sel_RS_E), 32'd5);
        flush();

        // jal ; jr $31 : PC8 from E, no stall
        nxt(); set_d(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd31, RES_PC8, MD_NONE, 1'b0);
        nxt(); set_d(5'd31, 5'd0, TUSE_D, TUSE_NONE, 5'd0, RES_ALU, MD_NONE, 1'b0);
        #1;
        chk("jal_sel_RS_D", 32'(hz.sel_RS_D), 32'd1);
        chk("jal_stall",    32'(hz.stall),    32'd0);
        flush();

        // jal ; nop ; jr $31 : PC8 from M
        nxt(); set_d(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd31, RES_PC8, MD_NONE, 1'b0);
        nxt(); idle();
        nxt(); set_d(5'd31, 5'd0, TUSE_D, TUSE_NONE, 5'd0, RES_ALU, MD_NONE, 1'b0);
        #1;
        chk("jalm_sel_RS_D", 32'(hz.sel_RS_D), 32'd4);
        chk("jalm_stall",    32'(hz.stall),    32'd0);
        flush();

        // ALU producer three ahead: WtDt on rt in D
        nxt(); set_d(5'd1, 5'd2, TUSE_E, TUSE_E, 5'd10, RES_ALU, MD_NONE, 1'b0);
        nxt(); idle();
        nxt(); idle();
        nxt(); set_d(5'd0, 5'd10, TUSE_NONE, TUSE_E, 5'd0, RES_ALU, MD_NONE, 1'b0);
        #1;
        chk("w_sel_RT_D", 32'(hz.sel_RT_D), 32'd5);
        flush();

        // mult ; mfhi : N+1 stall cycles, N busy cycles
        nxt(); set_d(5'd2, 5'd3, TUSE_E, TUSE_E, 5'd0, RES_ALU, MD_MULT, 1'b1);
        #1;
        chk("mult_stall0", 32'(hz.stall), 32'd0);
        nxt(); set_d(5'd0, 5'd0, TUSE_NONE, TUSE_NONE, 5'd8, RES_HILO, MD_NONE, 1'b1);
        n_st = 0;
        n_bz = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (!hz.stall) break;
            n_st++;
            if (hz.md_busy) n_bz++;
            @(negedge clk);
        end
        chk("mult_stall_cycles", 32'(n_st), 32'd6);
        chk("mult_busy_cycles",  32'(n_bz), 32'd5);
        chk("mult_busy_end",     32'(hz.md_busy),  32'd0);
        chk("mult_sel_RS_D",     32'(hz.sel_RS_D), 32'd0);
        flush();

        // lw $8 ; sw $8 : no stall, store data from W in M
        nxt(); set_d(5'd29, 5'd0, TUSE_E, TUSE_NONE, 5'd8, RES_LOAD, MD_NONE, 1'b0);
        nxt(); set_d(5'd29, 5'd8, TUSE_E, TUSE_M, 5'd0, RES_ALU, MD_NONE, 1'b0);
        #1;
        chk("sw_stall", 32'(hz.stall), 32'd0);
        nxt(); idle(); #1;
        chk("sw_sel_RT_E",  32'(hz.sel_RT_E), 32'd0);
        chk("sw_sel_RT_M0", 32'(hz.sel_RT_M), 32'd0);
        nxt(); #1;
        chk("sw_sel_RT_M1", 32'(hz.sel_RT_M), 32'd1);
        flush();

        // Write to $0 then read $0 : nothing forwards, no stall
        nxt(); set_d(5'd1, 5'd2, TUSE_E, TUSE_E, 5'd0, RES_ALU, MD_NONE, 1'b0);
        nxt(); set_d(5'd0, 5'd0, TUSE_D, TUSE_D, 5'd0, RES_ALU, MD_NONE, 1'b0);
        #1;
        chk("r0_sel_RS_D", 32'(hz.sel_RS_D), 32'd0);
        chk("r0_sel_RT_D", 32'(hz.sel_RT_D), 32'd0);
        chk("r0_stall",    32'(hz.stall),    32'd0);
        nxt(); idle(); #1;
        chk("r0_sel_RS_E", 32'(hz.sel_RS_E), 32'd0);
        chk("r0_sel_RT_E", 32'(hz.sel_RT_E), 32'd0);
        flush();

        // Stall cycles so far: 2 (lw/beq) + 1 (lw/addu) + 6 (mult/mfhi)
`ifdef HAZARD_STALL_CNT_EN
        chk("stall_cnt", hz.stall_cnt, 32'd9);
`else
        chk("stall_cnt", hz.stall_cnt, 32'd0);
`endif

        // div then reset mid-operation
        nxt(); set_d(5'd2, 5'd3, TUSE_E, TUSE_E, 5'd0, RES_ALU, MD_DIV, 1'b1);
        nxt(); idle();
        nxt(); #1;
        chk("div_busy", 32'(hz.md_busy), 32'd1);
        rst_n = 1'b0;
        nxt(); #1;
        chk("div_rst_busy",      32'(hz.md_busy), 32'd0);
        chk("div_rst_stall_cnt", hz.stall_cnt,    32'd0);
        rst_n = 1'b1;
        nxt(); #1;
        chk("div_post_busy", 32'(hz.md_busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
